// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: decides advance/stall/bubble/flush/freeze per cycle and owns halt.
// Define STALL_PERF_CNT_EN to build the stall-cycle and flush-event performance counters.
module hazard_stall_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int ECALL_REG   = 17,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_is_ecall,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_reg_write,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_mem_read,
  input  logic                  ex_mispredict,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  wb_halt,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_freeze,
  output logic                  halted,
  output logic                  mem_timeout,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_count
);

  localparam int                    CNT_W         = 16;
  localparam logic [CNT_W-1:0]      TIMEOUT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [REG_ADDR_W-1:0] ECALL_ADDR    = REG_ADDR_W'(ECALL_REG);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             mem_timeout_reg, mem_timeout_next;

  // ------------------------------------------------------------------
  // Hazard terms that forwarding cannot cover
  // ------------------------------------------------------------------
  logic [1:0]            src_use;
  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [1:0]            src_load_hit;
  logic                  load_use;
  logic                  ecall_haz;
  logic                  miss;

  assign src_use     = {id_use_rs2, id_use_rs1};
  assign src_addr[0] = id_rs1;
  assign src_addr[1] = id_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_load_hit[gi] = src_use[gi] && (src_addr[gi] == id_ex_rd);
    end
  endgenerate

  // rd != 0 also guarantees an x0 source operand never matches.
  assign load_use  = id_ex_mem_read && (id_ex_rd != '0) && (|src_load_hit);
  assign ecall_haz = id_is_ecall &&
                     ((id_ex_reg_write && (id_ex_rd == ECALL_ADDR)) ||
                      (ex_mem_mem_read && (ex_mem_rd == ECALL_ADDR)));
  assign miss      = dmem_req && !dmem_ready;

  // ------------------------------------------------------------------
  // RUN-state output rules, reused on the cycle a memory wait completes
  // ------------------------------------------------------------------
  logic run_pc_write, run_if_id_write, run_if_id_flush, run_id_ex_bubble, run_pipe_freeze;

  always_comb begin
    run_pc_write     = 1'b0;
    run_if_id_write  = 1'b0;
    run_if_id_flush  = 1'b0;
    run_id_ex_bubble = 1'b0;
    run_pipe_freeze  = 1'b0;
    if (miss) begin
      run_pipe_freeze  = 1'b1;
    end else if (ex_mispredict) begin
      run_pc_write     = 1'b1;
      run_if_id_write  = 1'b1;
      run_if_id_flush  = 1'b1;
      run_id_ex_bubble = 1'b1;
    end else if (load_use || ecall_haz) begin
      run_id_ex_bubble = 1'b1;
    end else begin
      run_pc_write     = 1'b1;
      run_if_id_write  = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // State-dependent outputs and next-state logic
  // ------------------------------------------------------------------
  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c, pipe_freeze_c, halted_c;

  always_comb begin
    pc_write_c       = 1'b0;
    if_id_write_c    = 1'b0;
    if_id_flush_c    = 1'b0;
    id_ex_bubble_c   = 1'b0;
    pipe_freeze_c    = 1'b0;
    halted_c         = 1'b0;
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;

    case (state_reg)
      ST_RUN: begin
        pc_write_c     = run_pc_write;
        if_id_write_c  = run_if_id_write;
        if_id_flush_c  = run_if_id_flush;
        id_ex_bubble_c = run_id_ex_bubble;
        pipe_freeze_c  = run_pipe_freeze;
        if (wb_halt) begin
          state_next = ST_HALTED;
        end else if (miss) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = '0;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          // Freeze releases in the completing cycle so the stalled work moves on immediately.
          pc_write_c     = run_pc_write;
          if_id_write_c  = run_if_id_write;
          if_id_flush_c  = run_if_id_flush;
          id_ex_bubble_c = run_id_ex_bubble;
          pipe_freeze_c  = run_pipe_freeze;
          state_next     = ST_RUN;
          wait_cnt_next  = '0;
        end else begin
          // EX is frozen, so a mispredict pulse here is stale and re-presented later.
          pipe_freeze_c = 1'b1;
          if (wait_cnt_reg != TIMEOUT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          end
          if (wait_cnt_next == TIMEOUT_LIMIT) begin
            mem_timeout_next = 1'b1;
          end
        end
      end

      ST_HALTED: begin
        pipe_freeze_c = 1'b1;
        halted_c      = 1'b1;
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  // Reset overrides the combinational outputs so the pipeline is held safe while reset is low.
  assign pc_write     = reset & pc_write_c;
  assign if_id_write  = reset & if_id_write_c;
  assign if_id_flush  = reset & if_id_flush_c;
  assign id_ex_bubble = ~reset | id_ex_bubble_c;
  assign pipe_freeze  = ~reset | pipe_freeze_c;
  assign halted       = reset & halted_c;
  assign mem_timeout  = mem_timeout_reg;

  // ------------------------------------------------------------------
  // Optional performance counters
  // ------------------------------------------------------------------
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (!pc_write_c && (state_reg != ST_HALTED) && (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (if_id_flush_c && (perf_flush_reg != 32'hFFFF_FFFF)) begin
        perf_flush_reg <= perf_flush_reg + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_reg;
  assign perf_flush_count  = perf_flush_reg;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed steps plus random traffic
// compared every cycle against a rule-level model of the controller.
module tb_hazard_stall_controller;

  localparam int MEM_TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, id_ex_rd, ex_mem_rd;
  logic       id_use_rs1, id_use_rs2, id_is_ecall;
  logic       id_ex_reg_write, id_ex_mem_read, ex_mem_mem_read;
  logic       ex_mispredict, dmem_req, dmem_ready, wb_halt;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted, mem_timeout;
  logic [31:0] perf_stall_cycles, perf_flush_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: core mode flags and counters
  bit     m_halted, m_waiting, m_timeout;
  int     m_wait;
  longint m_stall, m_flush;

  hazard_stall_controller #(.REG_ADDR_W(5), .ECALL_REG(17), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_ecall(id_is_ecall), .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mispredict(ex_mispredict), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .wb_halt(wb_halt),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .halted(halted),
    .mem_timeout(mem_timeout), .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0; ex_mem_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_is_ecall = 0;
    id_ex_reg_write = 0; id_ex_mem_read = 0; ex_mem_mem_read = 0;
    ex_mispredict = 0; dmem_req = 0; dmem_ready = 0; wb_halt = 0;
  endtask

  // Called just after a falling edge with inputs applied: checks outputs, then advances the model.
  task automatic cycle(input string tag);
    bit lu, eh, miss;
    bit e_pc, e_ifid, e_flush, e_bubble, e_freeze, e_halted;
    #1;
    if (!reset) begin
      m_halted = 0; m_waiting = 0; m_timeout = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end
    lu = id_ex_mem_read && (id_ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
    eh = id_is_ecall && ((id_ex_reg_write && id_ex_rd == 17) || (ex_mem_mem_read && ex_mem_rd == 17));
    miss = dmem_req && !dmem_ready;
    {e_pc, e_ifid, e_flush, e_bubble, e_freeze, e_halted} = '0;
    if (!reset) begin
      e_bubble = 1; e_freeze = 1;
    end else if (m_halted) begin
      e_freeze = 1; e_halted = 1;
    end else if ((m_waiting && !dmem_ready) || miss) begin
      e_freeze = 1;
    end else if (ex_mispredict) begin
      e_pc = 1; e_ifid = 1; e_flush = 1; e_bubble = 1;
    end else if (lu || eh) begin
      e_bubble = 1;
    end else begin
      e_pc = 1; e_ifid = 1;
    end

    chk({tag, ".pc_write"},     32'(pc_write),     32'(e_pc));
    chk({tag, ".if_id_write"},  32'(if_id_write),  32'(e_ifid));
    chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_flush));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bubble));
    chk({tag, ".pipe_freeze"},  32'(pipe_freeze),  32'(e_freeze));
    chk({tag, ".halted"},       32'(halted),       32'(e_halted));
    chk({tag, ".mem_timeout"},  32'(mem_timeout),  32'(m_timeout));
`ifdef STALL_PERF_CNT_EN
    chk({tag, ".perf_stall"},   perf_stall_cycles, 32'(m_stall));
    chk({tag, ".perf_flush"},   perf_flush_count,  32'(m_flush));
`else
    chk({tag, ".perf_stall"},   perf_stall_cycles, 32'd0);
    chk({tag, ".perf_flush"},   perf_flush_count,  32'd0);
`endif

    if (reset) begin
      if (!m_halted && !e_pc && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e_flush && m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_halted) begin
        // halt is left only through reset
      end else if (m_waiting) begin
        if (dmem_ready) begin
          m_waiting = 0; m_wait = 0;
        end else begin
          if (m_wait < MEM_TIMEOUT) m_wait++;
          if (m_wait == MEM_TIMEOUT) m_timeout = 1;
        end
      end else if (wb_halt) begin
        m_halted = 1;
      end else if (miss) begin
        m_waiting = 1; m_wait = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 5))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd16;
      3: return 5'd17;
      4: return 5'd6;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    clear_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    reset = 1'b1;
    cycle("idle");

    // Load-use through rs2: exactly one stall cycle
    id_ex_mem_read = 1; id_ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    cycle("load_use");
    clear_inputs();
    cycle("load_use_done");

    // Loads to x0 and ALU results never stall
    id_ex_mem_read = 1; id_ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    cycle("load_x0");
    clear_inputs();
    id_ex_reg_write = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cycle("alu_fwd");
    clear_inputs();

    // ecall reading x17 while it is still in flight
    id_is_ecall = 1; id_ex_reg_write = 1; id_ex_rd = 17;
    cycle("ecall_ex17");
    id_ex_rd = 16;
    cycle("ecall_ex16");
    clear_inputs();
    id_is_ecall = 1; ex_mem_mem_read = 1; ex_mem_rd = 17;
    cycle("ecall_mem17");
    clear_inputs();

    // Mispredict overrides a simultaneous load-use
    ex_mispredict = 1; id_ex_mem_read = 1; id_ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    cycle("mispredict_lu");
    clear_inputs();
    cycle("after_flush");

    // Long data-memory wait crossing the timeout threshold
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 300; i++) cycle($sformatf("mem_wait%0d", i));
    chk("timeout_sticky", 32'(mem_timeout), 32'd1);
    ex_mispredict = 1;
    cycle("wait_ignore_mispredict");
    ex_mispredict = 0;
    dmem_ready = 1;
    cycle("wait_ready");
    clear_inputs();
    cycle("wait_run");

    // Reset pulse in the middle of a wait
    dmem_req = 1;
    for (int i = 0; i < 10; i++) cycle($sformatf("wait2_%0d", i));
    reset = 0;
    cycle("reset_mid_wait");
    #1 chk("reset_clears_timeout", 32'(mem_timeout), 32'd0);
    clear_inputs();
    reset = 1;
    cycle("post_reset");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      id_rs1 = pick_reg(); id_rs2 = pick_reg(); id_ex_rd = pick_reg(); ex_mem_rd = pick_reg();
      id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
      id_is_ecall = ($urandom_range(0, 3) == 0);
      id_ex_reg_write = 1'($urandom_range(0, 1)); id_ex_mem_read = 1'($urandom_range(0, 1));
      ex_mem_mem_read = 1'($urandom_range(0, 1));
      ex_mispredict = ($urandom_range(0, 5) == 0);
      dmem_req = ($urandom_range(0, 2) == 0); dmem_ready = 1'($urandom_range(0, 1));
      wb_halt = ($urandom_range(0, 79) == 0);
      reset = ($urandom_range(0, 59) != 0);
      cycle($sformatf("rand%0d", i));
    end
    clear_inputs();
    reset = 0;
    cycle("rand_reset");
    reset = 1;
    cycle("rand_done");

    // Halt: permanent until reset
    wb_halt = 1;
    cycle("halt_req");
    wb_halt = 0;
    for (int i = 0; i < 5; i++) cycle($sformatf("halted%0d", i));
    #1 chk("halt_pc_write", 32'(pc_write), 32'd0);
    chk("halt_flag", 32'(halted), 32'd1);
    reset = 0;
    cycle("halt_reset");
    reset = 1;
    #1 chk("unhalt_pc_write", 32'(pc_write), 32'd1);
    chk("unhalt_flag", 32'(halted), 32'd0);
    cycle("unhalt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage gshare core. It decides, each cycle, whether the front end advances, stalls, bubbles or flushes. Inputs are load-use hazards, the ecall x17 read-in-ID hazard, branch/jump mispredicts from EX, and data-memory wait. The register forwarding unit resolves every hazard that forwarding can cover; this block handles only the hazards forwarding cannot cover. It also owns pipeline halt sequencing.

Parameters:
REG_ADDR_W, 5, register index width
ECALL_REG, 17, register read by ecall in ID
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout asserts (1..65535)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
id_rs1  input  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  input  REG_ADDR_W  rs2 index of instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_is_ecall  input  1  ID instruction is ecall
id_ex_rd  input  REG_ADDR_W  destination in EX
id_ex_reg_write  input  1  EX instruction writes rd
id_ex_mem_read  input  1  EX instruction is a load
ex_mem_rd  input  REG_ADDR_W  destination in MEM
ex_mem_mem_read  input  1  MEM instruction is a load
ex_mispredict  input  1  EX resolved a wrong next-PC (1-cycle pulse)
dmem_req  input  1  MEM stage accessing data memory
dmem_ready  input  1  data memory completes this cycle
wb_halt  input  1  halting ecall in WB
pc_write  output  1  PC register update enable
if_id_write  output  1  IF/ID register update enable
if_id_flush  output  1  clear IF/ID to nop
id_ex_bubble  output  1  load nop into ID/EX
pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB
halted  output  1  core halted
mem_timeout  output  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT
perf_stall_cycles  output  32  stall-cycle count (optional feature)
perf_flush_count  output  32  flush-event count (optional feature)

Behaviour:
- Async reset (reset=0): state=RUN, wait counter=0, mem_timeout=0, perf counters=0. While reset=0, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, pipe_freeze=1, halted=0.
- States: RUN, MEM_WAIT, HALTED. Outputs are combinational from the state and current inputs; state and counters are registered.
- Hazard terms, evaluated in RUN:
  - load_use = id_ex_mem_read & id_ex_rd!=0 & ((id_use_rs1 & id_rs1==id_ex_rd) | (id_use_rs2 & id_rs2==id_ex_rd)).
  - ecall_haz = id_is_ecall & ((id_ex_reg_write & id_ex_rd==ECALL_REG) | (ex_mem_mem_read & ex_mem_rd==ECALL_REG)).
  - miss = dmem_req & !dmem_ready.
- RUN priority, highest first:
  1. wb_halt: next state=HALTED. This cycle outputs follow the normal rules.
  2. miss: pipe_freeze=1, pc_write=0, if_id_write=0; next state=MEM_WAIT.
  3. ex_mispredict: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. This overrides load_use and ecall_haz.
  4. load_use or ecall_haz: pc_write=0, if_id_write=0, id_ex_bubble=1. Stall lasts 1 cycle; re-evaluated next cycle.
  5. Otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- MEM_WAIT:
  - pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  - ex_mispredict is ignored, because the EX stage is frozen and the pulse is re-presented after unfreeze.
  - Wait counter increments each cycle and saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset.
  - When dmem_ready=1: the freeze ends that cycle (pipe_freeze=0, RUN hazard rules apply to the other inputs), next state=RUN, counter cleared.
- HALTED: all enables 0, pipe_freeze=1, halted=1. Only reset exits this state.
- ID rs equal to 0 never causes a stall. Forwarding-resolvable hazards (ALU result in EX/MEM/WB) never stall.
- Reset asserted mid-MEM_WAIT or mid-stall: immediate return to the reset values, with no partial update.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- When defined:
  - perf_stall_cycles increments in every cycle with pc_write=0 while not HALTED and reset=1.
  - perf_flush_count increments on every cycle where if_id_flush=1.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: both ports are tied to 0 and no counter flops are built. The ports exist in both builds.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs2=5, id_use_rs2=1 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then pc_write=1.
- rd=0 load with id_rs1=0, id_use_rs1=1 -> no stall; ALU hazard (id_ex_reg_write=1, rd=5, not load) -> no stall.
- Ecall: id_is_ecall=1, id_ex_reg_write=1, id_ex_rd=17 -> 1-cycle stall. Same stimulus with rd=16 -> no stall.
- Mispredict together with load_use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; with STALL_PERF_CNT_EN, perf_flush_count 0->1.
- dmem_req=1, dmem_ready=0 for 300 cycles with MEM_TIMEOUT=255 -> pipe_freeze=1 throughout; mem_timeout rises after 255 MEM_WAIT cycles and stays at 1; dmem_ready=1 -> RUN next cycle. Pulse reset low mid-wait -> immediate reset values, mem_timeout=0.
- wb_halt=1 -> halted=1 from the next cycle, pc_write=0 permanently. Releasing reset -> halted=0, pc_write=1.
